// File: rtl/arb_pkg.sv
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types, constants and helpers for the round-robin
//                arbiter family.
//                  arb_state_t - arbiter FSM state encoding
//                  ARB_MAX_N   - largest supported requester count
//                  rr_next()   - circular successor of an index
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int ARB_MAX_N = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    // (idx + 1) mod n, without a divider; idx is assumed to be below n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : arb_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit found scanning upward from ptr, wrapping from
//                N-1 to 0.
//  Ports       : req     [N-1:0]  request vector
//                ptr     [SW-1:0] preferred (first-scanned) index, < N
//                winner  [SW-1:0] index of the selected requester
//                any_req          at least one request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 3,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] winner,
    output logic          any_req
);

    always_comb begin
        int w_idx;
        winner  = '0;
        any_req = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(ptr) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            // any_req doubles as the "already found" flag so the first hit wins
            if (!any_req && req[w_idx]) begin
                winner  = SW'(w_idx);
                any_req = 1'b1;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Central round-robin arbiter with a per-requester four-phase
//                req/ack handshake. A grant is held until the owner drops
//                its request; ownership then rotates to the next requester
//                after the previous owner.
//  Ports       : clk        clock, all state changes on posedge
//                rst        synchronous active-high reset
//                req        [N-1:0]  request, one bit per requester
//                ack        [N-1:0]  grant acknowledge, one-hot or zero
//                sel        [SW-1:0] index of the current owner
//                sel_valid           sel is meaningful (GRANT or BUSY)
//                overrun             sticky: owner held longer than MAX_HOLD
//  Config      : RR_ARBITER_HOLD_WATCHDOG_EN - when defined, a saturating
//                BUSY-cycle counter flags overrun; the grant is never
//                revoked. When undefined, overrun is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 3,
    parameter  int MAX_HOLD = 16,
    localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  ack,
    output logic [SW-1:0] sel,
    output logic          sel_valid,
    output logic          overrun
);

    generate
        if (N < 1 || N > ARB_MAX_N || MAX_HOLD < 1) begin : g_bad_param
            $error("rr_arbiter: N must be 1..16 and MAX_HOLD at least 1");
        end
    endgenerate

    arb_state_t    r_state;
    logic [SW-1:0] r_owner;
    logic [SW-1:0] r_ptr;
    logic [N-1:0]  r_ack;
    logic          r_sel_valid;

    logic [SW-1:0] w_winner;
    logic          w_any_req;
    logic [N-1:0]  w_owner_onehot;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_owner_onehot = N'(1) << r_owner;

`ifdef RR_ARBITER_HOLD_WATCHDOG_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] r_hold;
    logic          r_overrun;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_ack       <= '0;
            r_sel_valid <= 1'b0;
`ifdef RR_ARBITER_HOLD_WATCHDOG_EN
            r_hold      <= '0;
            r_overrun   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_winner;
                        r_sel_valid <= 1'b1;
                        r_state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (req[r_owner]) begin
                        r_ack   <= w_owner_onehot;
                        r_state <= ARB_BUSY;
`ifdef RR_ARBITER_HOLD_WATCHDOG_EN
                        r_hold  <= '0;
`endif
                    end else begin
                        // Request withdrawn before ack: abandon without
                        // advancing ptr so the same arbitration can recur.
                        r_sel_valid <= 1'b0;
                        r_state     <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    if (!req[r_owner]) begin
                        r_ack       <= '0;
                        r_sel_valid <= 1'b0;
                        r_ptr       <= SW'(rr_next(int'(r_owner), N));
                        r_state     <= ARB_IDLE;
                    end else begin
`ifdef RR_ARBITER_HOLD_WATCHDOG_EN
                        if (r_hold == HW'(MAX_HOLD)) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    r_ack       <= '0;
                    r_sel_valid <= 1'b0;
                    r_state     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign sel       = r_owner;
    assign sel_valid = r_sel_valid;

`ifdef RR_ARBITER_HOLD_WATCHDOG_EN
    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

endmodule : rr_arbiter

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Directed self-checking bench for rr_arbiter (N=3,
//                MAX_HOLD=4). Inputs change 1 time unit after each rising
//                edge; outputs are checked at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;

`ifdef RR_ARBITER_HOLD_WATCHDOG_EN
    localparam logic c_wd = 1'b1;
`else
    localparam logic c_wd = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] ack;
    logic [1:0] sel;
    logic       sel_valid;
    logic       overrun;

    int n_vec;
    int n_err;

    rr_arbiter #(
        .N        (3),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .sel       (sel),
        .sel_valid (sel_valid),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_ack,
                           input logic [1:0] e_sel, input logic e_sv);
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
        chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
        chk({tag, ".sel_valid"}, 32'(sel_valid), 32'(e_sv));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 3'b111;

        // Reset with all requests held
        tick(2);
        chk_out("reset", 3'b000, 2'd0, 1'b0);
        chk("reset.overrun", 32'(overrun), 32'd0);

        // First grant goes to requester 0, ack on the 2nd edge after release
        rst = 1'b0;
        tick(1);
        chk_out("g0_grant", 3'b000, 2'd0, 1'b1);
        tick(1);
        chk_out("g0_ack", 3'b001, 2'd0, 1'b1);
        tick(3);
        chk_out("g0_hold", 3'b001, 2'd0, 1'b1);
        chk("g0_hold.overrun", 32'(overrun), 32'd0);

        // Rotation 0 -> 1 -> 2 -> 0
        req = 3'b110;
        tick(1);
        chk_out("g0_rel", 3'b000, 2'd0, 1'b0);
        tick(1);
        chk_out("g1_grant", 3'b000, 2'd1, 1'b1);
        tick(1);
        chk_out("g1_ack", 3'b010, 2'd1, 1'b1);
        tick(3);
        req = 3'b101;
        tick(1);
        chk_out("g1_rel", 3'b000, 2'd1, 1'b0);
        tick(1);
        chk_out("g2_grant", 3'b000, 2'd2, 1'b1);
        tick(1);
        chk_out("g2_ack", 3'b100, 2'd2, 1'b1);
        tick(3);
        req = 3'b001;
        tick(1);
        chk_out("g2_rel", 3'b000, 2'd2, 1'b0);
        tick(2);
        chk_out("g0b_ack", 3'b001, 2'd0, 1'b1);

        // Wrap: ptr=1 after requester 0, req=101 -> 2 before 0
        req = 3'b000;
        tick(1);
        chk_out("g0b_rel", 3'b000, 2'd0, 1'b0);
        req = 3'b101;
        tick(1);
        chk_out("wrap_grant", 3'b000, 2'd2, 1'b1);
        tick(1);
        chk_out("wrap_ack", 3'b100, 2'd2, 1'b1);
        req = 3'b001;
        tick(1);
        chk_out("wrap_rel", 3'b000, 2'd2, 1'b0);
        tick(2);
        chk_out("wrap_g0_ack", 3'b001, 2'd0, 1'b1);
        req = 3'b000;
        tick(1);
        chk_out("wrap_g0_rel", 3'b000, 2'd0, 1'b0);

        // Abort: req[1] pulses one cycle; ptr must stay at 1
        req = 3'b010;
        tick(1);
        chk_out("abort_grant", 3'b000, 2'd1, 1'b1);
        req = 3'b000;
        tick(1);
        chk_out("abort_idle", 3'b000, 2'd1, 1'b0);
        tick(1);
        chk_out("abort_stay", 3'b000, 2'd1, 1'b0);
        req = 3'b011;
        tick(1);
        chk_out("abort_ptr", 3'b000, 2'd1, 1'b1);
        tick(1);
        chk_out("wd_ack", 3'b010, 2'd1, 1'b1);

        // Hold watchdog: owner 1 holds for 10 BUSY edges
        tick(4);
        chk("wd_4.overrun", 32'(overrun), 32'd0);
        tick(1);
        chk("wd_5.overrun", 32'(overrun), 32'(c_wd));
        chk_out("wd_5", 3'b010, 2'd1, 1'b1);
        tick(5);
        chk_out("wd_10", 3'b010, 2'd1, 1'b1);
        req = 3'b001;
        tick(1);
        chk_out("wd_rel", 3'b000, 2'd1, 1'b0);
        chk("wd_rel.overrun", 32'(overrun), 32'(c_wd));
        tick(2);
        chk_out("wd_next_ack", 3'b001, 2'd0, 1'b1);
        chk("wd_next.overrun", 32'(overrun), 32'(c_wd));

        // Reset while requester 2 is BUSY
        req = 3'b100;
        tick(1);
        chk_out("r2_rel0", 3'b000, 2'd0, 1'b0);
        tick(2);
        chk_out("r2_ack", 3'b100, 2'd2, 1'b1);
        rst = 1'b1;
        req = 3'b011;
        tick(1);
        chk_out("rst_busy", 3'b000, 2'd0, 1'b0);
        chk("rst_busy.overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(1);
        chk_out("rst_regrant", 3'b000, 2'd0, 1'b1);
        tick(1);
        chk_out("rst_ack", 3'b001, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_arbiter

`default_nettype wire
